// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the five-stage MIPS pipeline.
// It compares the operand needs of the D instruction (Tuse) against the
// result timing of older instructions in E and M (Tnew). It also tracks the
// multiply/divide unit busy window. On a hazard, F and D hold and E takes a
// bubble. A saturating counter records the number of stalled cycles.
module hazard_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_md,
  input  logic [4:0]  E_dst,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_dst,
  input  logic [1:0]  M_tnew,
  input  logic        E_start,
  input  logic        E_is_div,
  output logic        F_WE,
  output logic        D_WE,
  output logic        E_clr,
  output logic        M_WE,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  // Counter reload values, narrowed to the 4-bit busy counter width.
  localparam logic [3:0] MULT_LOAD = MULT_CYC[3:0];
  localparam logic [3:0] DIV_LOAD  = DIV_CYC[3:0];

  logic [3:0] md_cnt;
  logic       rs_stall;
  logic       rt_stall;
  logic       md_stall;
  logic       stall;

  // Register-dependency and MDU hazard detection. Register 0 is excluded
  // because it is never a real producer. A Tuse of 3 can never lose against
  // a Tnew of at most 2, so unused operands drop out naturally.
  always_comb begin
    rs_stall = 1'b0;
    rt_stall = 1'b0;
    md_stall = 1'b0;
    if (D_rs != 5'd0) begin
      rs_stall = ((D_rs == E_dst) && (E_tnew > D_rs_tuse)) ||
                 ((D_rs == M_dst) && (M_tnew > D_rs_tuse));
    end
    if (D_rt != 5'd0) begin
      rt_stall = ((D_rt == E_dst) && (E_tnew > D_rt_tuse)) ||
                 ((D_rt == M_dst) && (M_tnew > D_rt_tuse));
    end
    md_stall = D_md && (md_busy || E_start);
    stall    = rs_stall || rt_stall || md_stall;
  end

  // Pipeline register controls: hold F/D and bubble E while stalled.
  always_comb begin
    F_WE    = ~stall;
    D_WE    = ~stall;
    E_clr   = stall;
    M_WE    = 1'b1;
    md_busy = (md_cnt != 4'd0);
  end

  // MDU busy counter. A start while the counter is still running is a
  // protocol error, and the counter ignores it and keeps counting down.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= 4'd0;
    end else if (E_start && (md_cnt == 4'd0)) begin
      md_cnt <= E_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  // Saturating stall-cycle counter for performance debug.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
